// File: rtl/audio_sample_frontend.sv
// Codec-to-DFT sample front end: one-shot capture FSM, N-channel mix, gain shift with
// saturation, show-ahead output FIFO, decaying peak meter and clip/overflow status.
module audio_sample_frontend #(
  parameter int IN_WIDTH    = 24,
  parameter int OUT_WIDTH   = 16,
  parameter int CHANNELS    = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int METER_WIDTH = 10,
  parameter int DECAY_SHIFT = 4,
  parameter int CNT_WIDTH   = 8,
  localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         codecReadReady,
  output logic                         codecRead,
  input  logic [CHANNELS*IN_WIDTH-1:0] codecData,
  input  logic [1:0]                   mixMode,
  input  logic [SEL_W-1:0]             channelSel,
  input  logic [4:0]                   gainShift,
  output logic                         sampleReady,
  input  logic                         doingRead,
  output logic [OUT_WIDTH-1:0]         outSample,
  output logic [METER_WIDTH-1:0]       levelMeter,
  output logic                         clipFlag,
  input  logic                         clipClear,
  output logic [CNT_WIDTH-1:0]         overflowCount
);

  localparam int CW     = $clog2(CHANNELS);
  localparam int MW     = IN_WIDTH + CW + 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int MSHIFT = OUT_WIDTH - 1 - METER_WIDTH;
  localparam logic signed [MW-1:0] SMAX = {{(MW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [MW-1:0] SMIN = ~SMAX;
  localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, WAIT_LOW} state_t;
  state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (codecReadReady)  state_d = WAIT_LOW;
      WAIT_LOW: if (!codecReadReady) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Gated by rst so the strobe stays low while reset is held with ready high.
  always_comb begin
    codecRead = rst && (state_q == IDLE) && codecReadReady;
  end

  logic [CHANNELS*IN_WIDTH-1:0] cap_q;
  logic                         cap_v_q;
  logic signed [MW-1:0]         sum_c, one_c, ext_c, mix_d, mix_q;
  logic                         mix_v_q;

  always_comb begin
    sum_c = '0;
    one_c = {{(MW-IN_WIDTH){cap_q[IN_WIDTH-1]}}, cap_q[IN_WIDTH-1:0]};
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      ext_c = {{(MW-IN_WIDTH){cap_q[c*IN_WIDTH+IN_WIDTH-1]}}, cap_q[c*IN_WIDTH +: IN_WIDTH]};
      sum_c = sum_c + ext_c;
      if (SEL_W'(c) == channelSel) one_c = ext_c;
    end
    case (mixMode)
      2'd0:    mix_d = sum_c;
      2'd1:    mix_d = sum_c >>> CW;
      2'd2:    mix_d = one_c;
      default: mix_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q   <= '0;
      cap_v_q <= 1'b0;
      mix_q   <= '0;
      mix_v_q <= 1'b0;
    end else begin
      cap_v_q <= codecRead;
      if (codecRead) cap_q <= codecData;
      mix_v_q <= cap_v_q;
      if (cap_v_q) mix_q <= mix_d;
    end
  end

  logic signed [MW-1:0]   shifted_c;
  logic [OUT_WIDTH-1:0]   sat_c, mag_c;
  logic                   clip_c;

  always_comb begin
    shifted_c = mix_q >>> gainShift;
    clip_c    = 1'b1;
    if (shifted_c > SMAX)      sat_c = SAT_MAX;
    else if (shifted_c < SMIN) sat_c = SAT_MIN;
    else begin
      sat_c  = shifted_c[OUT_WIDTH-1:0];
      clip_c = 1'b0;
    end
    if (sat_c == SAT_MIN)          mag_c = SAT_MAX;
    else if (sat_c[OUT_WIDTH-1])   mag_c = -sat_c;
    else                           mag_c = sat_c;
  end

  logic [OUT_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic [CNT_WIDTH-1:0]   ovf_q, ovf_d;
  logic [METER_WIDTH-1:0] level_q, level_d, m_c, decay_c;
  logic                   clip_q, clip_d;
  logic                   push, pop, full, empty, wr_en;

  always_comb begin
    push     = mix_v_q;
    empty    = (count_q == '0);
    full     = (count_q == (AW+1)'(FIFO_DEPTH));
    pop      = doingRead && !empty;
    wr_en    = push && (!full || pop);
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_en && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !wr_en) count_d = count_q - (AW+1)'(1);
    ovf_d = ovf_q;
    if (push && full && !pop && !(&ovf_q)) ovf_d = ovf_q + CNT_WIDTH'(1);
    // Meter moves on every stage-2 sample, including those dropped on a full FIFO.
    m_c     = METER_WIDTH'(mag_c >> MSHIFT);
    decay_c = level_q - (level_q >> DECAY_SHIFT);
    level_d = level_q;
    if (push) level_d = (m_c > decay_c) ? m_c : decay_c;
    clip_d = clip_q;
    if (clipClear)            clip_d = 1'b0;
    else if (push && clip_c)  clip_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= sat_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= '0;
      level_q  <= '0;
      clip_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      level_q  <= level_d;
      clip_q   <= clip_d;
    end
  end

  assign sampleReady   = !empty;
  assign outSample     = empty ? '0 : mem_q[rd_ptr_q];
  assign levelMeter    = level_q;
  assign clipFlag      = clip_q;
  assign overflowCount = ovf_q;

endmodule

// File: tb/tb_audio_sample_frontend.sv
// Bench for audio_sample_frontend: mix/scale vector table, capture pulse and latency,
// FIFO overflow, reset mid-operation and meter decay, with a scoreboard on every pop.
module tb_audio_sample_frontend;

  logic        clk = 1'b0;
  logic        rst;
  logic        codecReadReady, codecRead;
  logic [47:0] codecData;
  logic [1:0]  mixMode;
  logic        channelSel;
  logic [4:0]  gainShift;
  logic        sampleReady, doingRead;
  logic [15:0] outSample;
  logic [9:0]  levelMeter;
  logic        clipFlag, clipClear;
  logic [7:0]  overflowCount;

  audio_sample_frontend #(
    .IN_WIDTH(24), .OUT_WIDTH(16), .CHANNELS(2), .FIFO_DEPTH(8),
    .METER_WIDTH(10), .DECAY_SHIFT(4), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .codecReadReady(codecReadReady), .codecRead(codecRead),
    .codecData(codecData), .mixMode(mixMode), .channelSel(channelSel),
    .gainShift(gainShift), .sampleReady(sampleReady), .doingRead(doingRead),
    .outSample(outSample), .levelMeter(levelMeter), .clipFlag(clipFlag),
    .clipClear(clipClear), .overflowCount(overflowCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic        sel;
    logic [4:0]  gain;
    logic [23:0] l;
    logic [23:0] r;
    logic [15:0] exp;
    logic        clip;
  } vec_t;

  vec_t        vecs [10];
  logic [15:0] exp_q [$];
  logic [15:0] mon_exp;
  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [1:0] mode, input logic sel,
                                        input logic [4:0] gain, input logic [23:0] l,
                                        input logic [23:0] r);
    longint a, b, mx;
    a = longint'($signed(l));
    b = longint'($signed(r));
    case (mode)
      2'd0:    mx = a + b;
      2'd1:    mx = (a + b) >>> 1;
      2'd2:    mx = sel ? b : a;
      default: mx = 0;
    endcase
    mx = mx >>> gain;
    if (mx > 32767)  mx = 32767;
    if (mx < -32768) mx = -32768;
    return mx[15:0];
  endfunction

  function automatic logic [9:0] meter_next(input logic [9:0] lvl, input logic [15:0] s);
    int mag, m, d;
    mag = int'($signed(s));
    if (mag < 0) mag = -mag;
    if (mag > 32767) mag = 32767;
    m = mag >> 5;
    d = int'(lvl) - (int'(lvl) >> 4);
    return 10'((m > d) ? m : d);
  endfunction

  always @(negedge clk) begin
    if (codecRead) rd_cnt++;
    if (rst && doingRead && sampleReady) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fifo_pop: got %0h expected no sample", outSample);
      end else begin
        mon_exp = exp_q.pop_front();
        if (outSample !== mon_exp) begin
          errors++;
          $display("FAIL fifo_pop: got %0h expected %0h", outSample, mon_exp);
        end
      end
    end
  end

  task automatic episode(input logic [23:0] l, input logic [23:0] r);
    @(posedge clk); #1;
    codecData = {r, l};
    codecReadReady = 1'b1;
    @(posedge clk); #1;
    codecReadReady = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pop_one();
    int n = 0;
    while (!sampleReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!sampleReady) begin
      checks++;
      errors++;
      $display("FAIL pop_timeout: got sampleReady 0 expected 1");
    end else begin
      @(posedge clk); #1;
      doingRead = 1'b1;
      @(posedge clk); #1;
      doingRead = 1'b0;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] l, r;
    logic [15:0] e;
    logic [9:0]  lvl, prev;
    int          rd0;

    vecs[0] = '{2'd0, 1'b0, 5'd8, 24'h100000, 24'h100000, 16'h2000, 1'b0};
    vecs[1] = '{2'd0, 1'b0, 5'd8, 24'h7FFFFF, 24'h7FFFFF, 16'h7FFF, 1'b1};
    vecs[2] = '{2'd0, 1'b0, 5'd8, 24'h800000, 24'h800000, 16'h8000, 1'b1};
    vecs[3] = '{2'd1, 1'b0, 5'd0, 24'h000200, 24'h000600, 16'h0400, 1'b0};
    vecs[4] = '{2'd2, 1'b1, 5'd0, 24'h000200, 24'h000600, 16'h0600, 1'b0};
    vecs[5] = '{2'd3, 1'b0, 5'd0, 24'h000200, 24'h000600, 16'h0000, 1'b0};
    vecs[6] = '{2'd2, 1'b0, 5'd0, 24'h000200, 24'h000600, 16'h0200, 1'b0};
    vecs[7] = '{2'd0, 1'b0, 5'd0, 24'h000200, 24'h000600, 16'h0800, 1'b0};
    vecs[8] = '{2'd0, 1'b0, 5'd0, 24'h7FFFFF, 24'h000000, 16'h7FFF, 1'b1};
    vecs[9] = '{2'd1, 1'b0, 5'd4, 24'hFFFFF0, 24'hFFFFF0, 16'hFFFF, 1'b0};

    rst = 1'b0; codecReadReady = 1'b0; codecData = '0; mixMode = 2'd0;
    channelSel = 1'b0; gainShift = 5'd8; doingRead = 1'b0; clipClear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_codecRead", codecRead, 0);
    check("rst_sampleReady", sampleReady, 0);
    check("rst_outSample", outSample, 0);
    check("rst_level", levelMeter, 0);
    check("rst_clip", clipFlag, 0);
    check("rst_ovf", overflowCount, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Ready held high for 20 cycles: one pulse, sample visible three cycles later.
    @(posedge clk); #1;
    rd0 = rd_cnt;
    codecData = {24'h100000, 24'h100000};
    codecReadReady = 1'b1;
    exp_q.push_back(model(2'd0, 1'b0, 5'd8, 24'h100000, 24'h100000));
    @(negedge clk); check("read_pulse", codecRead, 1);
    @(negedge clk); check("lat_n1", sampleReady, 0);
    @(negedge clk); check("lat_n2", sampleReady, 0);
    @(negedge clk); check("lat_n3", sampleReady, 1);
    check("lat_data", outSample, 16'h2000);
    repeat (16) @(negedge clk);
    @(posedge clk); #1;
    codecReadReady = 1'b0;
    @(negedge clk); check("one_pulse", rd_cnt - rd0, 1);
    pop_one();
    exp_q.push_back(model(2'd0, 1'b0, 5'd8, 24'h100000, 24'h100000));
    episode(24'h100000, 24'h100000);
    check("second_pulse", rd_cnt - rd0, 2);
    pop_one();

    for (int i = 0; i < 10; i++) begin
      mixMode = vecs[i].mode;
      channelSel = vecs[i].sel;
      gainShift = vecs[i].gain;
      @(posedge clk); #1; clipClear = 1'b1;
      @(posedge clk); #1; clipClear = 1'b0;
      exp_q.push_back(vecs[i].exp);
      episode(vecs[i].l, vecs[i].r);
      pop_one();
      check($sformatf("clip_vec%0d", i), clipFlag, vecs[i].clip);
    end

    // Clear held through a saturating sample wins over the set.
    mixMode = 2'd0; gainShift = 5'd0; clipClear = 1'b1;
    exp_q.push_back(16'h7FFF);
    episode(24'h7FFFFF, 24'h7FFFFF);
    pop_one();
    check("clip_clear_prio", clipFlag, 0);
    clipClear = 1'b0;

    // Ten samples into an eight-entry FIFO with no consumer.
    gainShift = 5'd8;
    for (int i = 0; i < 10; i++) begin
      l = 24'($urandom);
      r = 24'($urandom);
      if (i < 8) exp_q.push_back(model(2'd0, 1'b0, 5'd8, l, r));
      episode(l, r);
    end
    repeat (3) @(posedge clk);
    #1;
    check("ovf_count", overflowCount, 2);
    check("ovf_full_ready", sampleReady, 1);
    l = 24'($urandom);
    r = 24'($urandom);
    exp_q.push_back(model(2'd0, 1'b0, 5'd8, l, r));
    episode(l, r);
    doingRead = 1'b1;
    @(posedge clk); #1;
    doingRead = 1'b0;
    check("ovf_simul", overflowCount, 2);
    for (int i = 0; i < 8; i++) pop_one();
    check("drained", sampleReady, 0);
    check("queue_empty", exp_q.size(), 0);

    // Reset with three buffered samples and the FSM parked in WAIT_LOW.
    for (int i = 0; i < 3; i++) episode(24'h010000 * 24'(i + 1), 24'h001000);
    @(posedge clk); #1;
    codecData = {24'h100000, 24'h100000};
    codecReadReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_sampleReady", sampleReady, 0);
    check("mid_rst_codecRead", codecRead, 0);
    check("mid_rst_ovf", overflowCount, 0);
    check("mid_rst_level", levelMeter, 0);
    exp_q.delete();
    codecReadReady = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    rd0 = rd_cnt;
    e = model(2'd0, 1'b0, 5'd8, 24'h040000, 24'h020000);
    exp_q.push_back(e);
    episode(24'h040000, 24'h020000);
    check("post_rst_read", rd_cnt - rd0, 1);
    pop_one();
    lvl = meter_next(10'd0, e);
    check("post_rst_level", levelMeter, lvl);

    // Meter: full-scale peak then decay on zero samples.
    gainShift = 5'd0;
    exp_q.push_back(16'h7FFF);
    episode(24'h007FFF, 24'h000000);
    pop_one();
    lvl = meter_next(lvl, 16'h7FFF);
    check("meter_peak", levelMeter, 10'h3FF);
    for (int i = 0; i < 6; i++) begin
      prev = levelMeter;
      exp_q.push_back(16'h0000);
      episode(24'h000000, 24'h000000);
      pop_one();
      lvl = meter_next(lvl, 16'h0000);
      if (i == 0) check("meter_decay1", levelMeter, 10'h3C0);
      if (i == 1) check("meter_decay2", levelMeter, 10'h384);
      check($sformatf("meter_model%0d", i), levelMeter, lvl);
      check($sformatf("meter_falls%0d", i), levelMeter < prev, 1);
    end
    gainShift = 5'd8;
    exp_q.push_back(16'h8000);
    episode(24'h800000, 24'h800000);
    pop_one();
    check("meter_negfs", levelMeter, 10'h3FF);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
